mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  RISC-V MEM pipeline stage: consumer of the EX/MEM register (ExMem_*), producer of the MEM/WB register (MemWb_*).
//  Drives loads and stores onto a valid/ready data-memory port that can stall for any number of cycles.
//  Sign- or zero-extends sub-word loads.
//  Generates mem_stall for all upstream stages.
//  Drives Wb_RegWData, the write-back / MEM-WB forwarding value consumed by the EX forwarding path.
// PARAMETERS
//  XLEN      32   datapath width; only 32 is supported
//  MAX_WAIT  255  cycles allowed in REQ+WAIT before a bus timeout; 8-bit counter
// PORTS
//  clk              in   1     clock
//  rst              in   1     synchronous, active-high reset
//  ExMem_AluResult  in   32    effective address, or ALU result for non-memory ops
//  ExMem_AluB_Pc4   in   32    store data (rs2)
//  ExMem_Funct3     in   3     access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ExMem_MemRead    in   1     load
//  ExMem_MemWrite   in   1     store
//  ExMem_MemToReg   in   1     write-back selects load data
//  ExMem_RegRd      in   5     destination register
//  ExMem_RegWrite   in   1     register write enable
//  dmem_req_valid   out  1     request valid
//  dmem_req_ready   in   1     request accepted
//  dmem_addr        out  32    word-aligned address {addr[31:2],2'b00}
//  dmem_we          out  1     1 = write
//  dmem_wstrb       out  4     byte strobes
//  dmem_wdata       out  32    lane-replicated store data
//  dmem_rsp_valid   in   1     read data valid / write acknowledge
//  dmem_rdata       in   32    read word
//  mem_stall        out  1     upstream stages must hold and ExMem_* must stay stable
//  mem_misalign     out  1     one-cycle pulse: misaligned access dropped
//  mem_err          out  1     one-cycle pulse: bus timeout
//  MemWb_RegRd      out  5     registered destination register
//  MemWb_RegWrite   out  1     registered write enable
//  Wb_RegWData      out  32    MemWb_MemToReg ? MemWb_LoadData : MemWb_AluResult (combinational from MEM/WB regs)
// BEHAVIOUR
//  Reset: state=IDLE, wait counter=0, all MemWb_* regs=0, mem_misalign=0, mem_err=0, dmem_req_valid=0.
//   Reset mid-transaction abandons the access; dmem_rsp_valid arriving later in IDLE/REQ is ignored.
//  memop = ExMem_MemRead|ExMem_MemWrite.
//  misal = (H/HU & addr[0]) | (W & addr[1:0]!=0).
//  Non-memop in IDLE: no stall; MEM/WB regs load ExMem_* on the next edge (1-cycle latency).
//  FSM IDLE -> REQ -> WAIT -> DONE -> IDLE:
//   IDLE: memop & !misal -> REQ, mem_stall=1.
//    memop & misal -> no request, no stall; next edge MemWb_RegWrite<=0, mem_misalign<=1.
//   REQ: dmem_req_valid=1; addr/we/wstrb/wdata held stable until ready; valid & ready -> WAIT. mem_stall=1.
//   WAIT: dmem_rsp_valid -> capture extended rdata (loads) -> DONE. mem_stall=1.
//   DONE: mem_stall=0; next edge commits MemWb_* (stores: RegWrite=0 as supplied) -> IDLE.
//    Minimum memory-op cost is 3 stall cycles (ready and rsp in the first cycle each).
//  While mem_stall=1, the MEM/WB regs get a bubble: MemWb_RegWrite<=0; RegRd/data are don't-care.
//  Timeout: counter runs in REQ and WAIT and clears on leaving DONE.
//   When it reaches MAX_WAIT -> DONE; on that commit MemWb_RegWrite<=0 and mem_err<=1.
//   dmem_req_valid drops on entering DONE.
//  Store lanes, sh = addr[1:0]:
//   SB: wstrb=4'b0001<<sh, wdata={4{rs2[7:0]}}.
//   SH: wstrb=4'b0011<<sh, wdata={2{rs2[15:0]}}.
//   SW: wstrb=4'hF, wdata=rs2.
//  Loads: select the lane = rdata>>(8*sh); LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
//  Unsupported funct3 (011, 110, 111) with memop: treated as misaligned (dropped, mem_misalign pulse).
//  MemRead & MemWrite both 1: treated as a store.
//  A response and a new request are never in flight together; the stage has one outstanding access.
// STRUCTURE
//  riscv_pkg: funct3 size constants (F3_B/H/W/BU/HU), MEM FSM state encodings, XLEN.
//  Sub-module lsu_align (combinational): store strobe/data generation, load lane-select/extend, misal.
//  mem_stage holds the FSM, the wait counter, the request-holding regs and the MEM/WB regs.
// TESTING
//  ALU op, RegWrite=1, Rd=5, AluResult=0x1234 -> next cycle MemWb_RegRd=5, Wb_RegWData=0x1234, mem_stall=0 throughout.
//  LB at addr 0x103, rdata=0x80FF_FF00, ready & rsp immediate -> stall 3 cycles, Wb_RegWData=0xFFFF_FF80; same with LBU -> 0x0000_0080.
//  SH at addr 0x202, rs2=0xABCD -> dmem_wstrb=4'b1100, dmem_wdata=0xABCD_ABCD, dmem_addr=0x200, we=1; MemWb_RegWrite=0.
//  LW with ready held 0 for 4 cycles -> valid/addr stable for all 4 cycles, stall persists until the DONE cycle.
//  LW at 0x101 -> no dmem_req_valid, mem_misalign one pulse, MemWb_RegWrite=0; MAX_WAIT=8, rsp never returns -> mem_err pulse after 8 cycles.
//  rst asserted in WAIT, then rsp_valid=1 -> state IDLE, outputs 0, response ignored, next LW completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: datapath width, load/store funct3 codes and MEM-stage FSM states.
package riscv_pkg;
    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_e;
endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes/replicated data, load lane select and extension,
// and alignment/size legality of the access.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] st_data_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      wstrb_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] ldata_o,
    output logic            misal_o
);
    logic [XLEN-1:0] lane;

    always_comb begin
        wstrb_o = 4'hF;
        wdata_o = st_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                wstrb_o = 4'b0011 << addr_lo_i;
                wdata_o = {2{st_data_i[15:0]}};
            end
            default: begin
                wstrb_o = 4'hF;
                wdata_o = st_data_i;
            end
        endcase
    end

    assign lane = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        case (funct3_i)
            F3_B:    ldata_o = {{24{lane[7]}}, lane[7:0]};
            F3_BU:   ldata_o = {24'h0, lane[7:0]};
            F3_H:    ldata_o = {{16{lane[15]}}, lane[15:0]};
            F3_HU:   ldata_o = {16'h0, lane[15:0]};
            default: ldata_o = lane;
        endcase
    end

    // Unsupported size codes are folded into the misaligned path so they are dropped.
    always_comb begin
        case (funct3_i)
            F3_B, F3_BU: misal_o = 1'b0;
            F3_H, F3_HU: misal_o = addr_lo_i[0];
            F3_W:        misal_o = |addr_lo_i;
            default:     misal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// RISC-V MEM stage: drives one outstanding valid/ready data-memory access, stalls upstream
// while it is in flight, and owns the MEM/WB pipeline register.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] ExMem_AluResult,
    input  logic [XLEN-1:0] ExMem_AluB_Pc4,
    input  logic [2:0]      ExMem_Funct3,
    input  logic            ExMem_MemRead,
    input  logic            ExMem_MemWrite,
    input  logic            ExMem_MemToReg,
    input  logic [4:0]      ExMem_RegRd,
    input  logic            ExMem_RegWrite,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_we,
    output logic [3:0]      dmem_wstrb,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            mem_stall,
    output logic            mem_misalign,
    output logic            mem_err,
    output logic [4:0]      MemWb_RegRd,
    output logic            MemWb_RegWrite,
    output logic [XLEN-1:0] Wb_RegWData
);
    mem_state_e      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            to_q, to_d;
    logic [XLEN-1:0] addr_q, wdata_q, ld_q;
    logic [3:0]      wstrb_q;
    logic            we_q;
    logic            misalign_q, err_q;

    logic [4:0]      wb_rd_q;
    logic            wb_we_q, wb_m2r_q;
    logic [XLEN-1:0] wb_alu_q, wb_ld_q;

    logic            memop, misal, start, last_wait;
    logic [3:0]      st_wstrb;
    logic [XLEN-1:0] st_wdata, ld_data;

    lsu_align u_align (
        .funct3_i  (ExMem_Funct3),
        .addr_lo_i (ExMem_AluResult[1:0]),
        .st_data_i (ExMem_AluB_Pc4),
        .rdata_i   (dmem_rdata),
        .wstrb_o   (st_wstrb),
        .wdata_o   (st_wdata),
        .ldata_o   (ld_data),
        .misal_o   (misal)
    );

    assign memop     = ExMem_MemRead | ExMem_MemWrite;
    assign start     = (state_q == MEM_IDLE) & memop & ~misal;
    assign last_wait = (cnt_q == 8'(MAX_WAIT - 1));

    // Timeout wins over a late request handshake; a response in WAIT wins over timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        case (state_q)
            MEM_IDLE: begin
                cnt_d = 8'd0;
                to_d  = 1'b0;
                if (start) state_d = MEM_REQ;
            end
            MEM_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (last_wait) begin
                    state_d = MEM_DONE;
                    to_d    = 1'b1;
                end else if (dmem_req_ready) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (dmem_rsp_valid) begin
                    state_d = MEM_DONE;
                end else if (last_wait) begin
                    state_d = MEM_DONE;
                    to_d    = 1'b1;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = MEM_IDLE;
            end
        endcase
    end

    assign mem_stall      = start | (state_q == MEM_REQ) | (state_q == MEM_WAIT);
    assign dmem_req_valid = (state_q == MEM_REQ);
    assign dmem_addr      = addr_q;
    assign dmem_we        = we_q;
    assign dmem_wstrb     = wstrb_q;
    assign dmem_wdata     = wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MEM_IDLE;
            cnt_q      <= 8'd0;
            to_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= 4'h0;
            we_q       <= 1'b0;
            ld_q       <= '0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_we_q    <= 1'b0;
            wb_m2r_q   <= 1'b0;
            wb_alu_q   <= '0;
            wb_ld_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;

            if (start) begin
                addr_q  <= {ExMem_AluResult[XLEN-1:2], 2'b00};
                we_q    <= ExMem_MemWrite;
                wstrb_q <= ExMem_MemWrite ? st_wstrb : 4'h0;
                wdata_q <= st_wdata;
            end

            if ((state_q == MEM_WAIT) && dmem_rsp_valid) ld_q <= ld_data;

            // MEM/WB: bubble while stalled, commit from DONE, pass through otherwise.
            if (mem_stall) begin
                wb_we_q <= 1'b0;
            end else begin
                wb_rd_q  <= ExMem_RegRd;
                wb_m2r_q <= ExMem_MemToReg;
                wb_alu_q <= ExMem_AluResult;
                wb_ld_q  <= ld_q;
                if (state_q == MEM_DONE) begin
                    wb_we_q <= ExMem_RegWrite & ~to_q;
                    err_q   <= to_q;
                end else begin
                    wb_we_q    <= ExMem_RegWrite & ~memop;
                    misalign_q <= memop;
                end
            end
        end
    end

    assign mem_misalign   = misalign_q;
    assign mem_err        = err_q;
    assign MemWb_RegRd    = wb_rd_q;
    assign MemWb_RegWrite = wb_we_q;
    assign Wb_RegWData    = wb_m2r_q ? wb_ld_q : wb_alu_q;
endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage: a transaction-level memory/pipeline model predicts every
// cycle's stall/request outputs and each MEM/WB commit.
module tb_mem_stage;
    localparam int MW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ExMem_AluResult, ExMem_AluB_Pc4;
    logic [2:0]  ExMem_Funct3;
    logic        ExMem_MemRead, ExMem_MemWrite, ExMem_MemToReg, ExMem_RegWrite;
    logic [4:0]  ExMem_RegRd;
    logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        mem_stall, mem_misalign, mem_err;
    logic [4:0]  MemWb_RegRd;
    logic        MemWb_RegWrite;
    logic [31:0] Wb_RegWData;

    mem_stage #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .ExMem_AluResult(ExMem_AluResult), .ExMem_AluB_Pc4(ExMem_AluB_Pc4),
        .ExMem_Funct3(ExMem_Funct3), .ExMem_MemRead(ExMem_MemRead),
        .ExMem_MemWrite(ExMem_MemWrite), .ExMem_MemToReg(ExMem_MemToReg),
        .ExMem_RegRd(ExMem_RegRd), .ExMem_RegWrite(ExMem_RegWrite),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
        .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .mem_misalign(mem_misalign), .mem_err(mem_err),
        .MemWb_RegRd(MemWb_RegRd), .MemWb_RegWrite(MemWb_RegWrite), .Wb_RegWData(Wb_RegWData)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem [0:63];
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_wstrb;
    logic        last_we;
    int          last_stalls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit f3_bad(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sh,
                                               input logic [2:0] f3);
        logic [7:0] b [4];
        for (int k = 0; k < 4; k++) b[k] = word[8*k +: 8];
        case (f3)
            3'b000:  return {{24{b[sh][7]}}, b[sh]};
            3'b100:  return {24'h0, b[sh]};
            3'b001:  return {{16{b[sh+2'd1][7]}}, b[sh+2'd1], b[sh]};
            3'b101:  return {16'h0, b[sh+2'd1], b[sh]};
            default: return word;
        endcase
    endfunction

    task automatic set_nop();
        ExMem_MemRead = 1'b0; ExMem_MemWrite = 1'b0; ExMem_MemToReg = 1'b0;
        ExMem_RegWrite = 1'b0; ExMem_RegRd = 5'd0; ExMem_Funct3 = 3'b000;
        ExMem_AluResult = 32'd0; ExMem_AluB_Pc4 = 32'd0;
    endtask

    // One instruction through MEM: R = extra cycles before ready, S = extra cycles before response.
    task automatic run_op(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                          input bit regw, input int R, input int S);
        bit          memop, mis, go, to, mtr, vld, rw_exp;
        int          n, sz, idx, sh;
        logic [3:0]  e_strb;
        logic [31:0] e_wd, e_ld;
        memop = rd_en | wr_en;
        sz    = acc_size(f3);
        mis   = memop && (f3_bad(f3) || ((int'(addr[1:0]) % sz) != 0));
        go    = memop && !mis;
        mtr   = rd_en && !wr_en;
        idx   = int'(addr[7:2]);
        sh    = int'(addr[1:0]);
        n     = R + S + 2;
        to    = go && (n > MW);
        if (to) n = MW;
        e_strb = 4'h0;
        e_wd   = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (k >= sh && k < sh + sz) e_strb[k] = 1'b1;
            e_wd[8*k +: 8] = rs2[8*(k % sz) +: 8];
        end
        e_ld = model_load(mem[idx], addr[1:0], f3);
        last_stalls = 0;

        @(posedge clk); #1;
        ExMem_MemRead = rd_en; ExMem_MemWrite = wr_en; ExMem_MemToReg = mtr;
        ExMem_RegWrite = regw; ExMem_RegRd = rd; ExMem_Funct3 = f3;
        ExMem_AluResult = addr; ExMem_AluB_Pc4 = rs2;

        if (go) begin
            for (int c = 0; c <= n + 1; c++) begin
                @(negedge clk);
                if (mem_stall) last_stalls++;
                chk1("stall", mem_stall, c <= n);
                vld = (c >= 1) && (c <= R + 1) && (c <= n);
                chk1("req_valid", dmem_req_valid, vld);
                if (vld) begin
                    chk("req_addr", dmem_addr, {addr[31:2], 2'b00});
                    chk1("req_we", dmem_we, wr_en);
                    if (wr_en) begin
                        chk("req_wstrb", {28'd0, dmem_wstrb}, {28'd0, e_strb});
                        chk("req_wdata", dmem_wdata, e_wd);
                    end
                    last_addr = dmem_addr; last_we = dmem_we;
                    last_wstrb = dmem_wstrb; last_wdata = dmem_wdata;
                end
                chk1("misalign_idle", mem_misalign, 1'b0);
                chk1("err_idle", mem_err, 1'b0);
                dmem_req_ready = (c == R + 1);
                dmem_rsp_valid = !to && (c == R + S + 2);
                dmem_rdata     = dmem_rsp_valid ? mem[idx] : $urandom();
                if (dmem_rsp_valid && wr_en)
                    for (int k = 0; k < 4; k++)
                        if (e_strb[k]) mem[idx][8*k +: 8] = e_wd[8*k +: 8];
            end
        end else begin
            @(negedge clk);
            chk1("stall_none", mem_stall, 1'b0);
            chk1("req_valid_none", dmem_req_valid, 1'b0);
        end

        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        set_nop();
        @(negedge clk);
        rw_exp = regw && !mis && !to;
        chk1("wb_we", MemWb_RegWrite, rw_exp);
        if (rw_exp) begin
            chk("wb_rd", {27'd0, MemWb_RegRd}, {27'd0, rd});
            chk("wb_data", Wb_RegWData, mtr ? e_ld : addr);
        end
        chk1("misalign", mem_misalign, mis);
        chk1("err", mem_err, to);
        chk1("req_valid_after", dmem_req_valid, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = $urandom();
        rst = 1'b1;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = 32'd0;
        set_nop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_valid", dmem_req_valid, 1'b0);
        chk1("rst_stall", mem_stall, 1'b0);
        chk1("rst_misalign", mem_misalign, 1'b0);
        chk1("rst_err", mem_err, 1'b0);
        chk1("rst_wb_we", MemWb_RegWrite, 1'b0);
        chk("rst_wb_rd", {27'd0, MemWb_RegRd}, 32'd0);
        chk("rst_wb_data", Wb_RegWData, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(0, 0, 3'b000, 32'h0000_1234, 32'd0, 5'd5, 1, 0, 0);
        chk("alu_lit_rd", {27'd0, MemWb_RegRd}, 32'd5);
        chk("alu_lit_data", Wb_RegWData, 32'h0000_1234);

        mem[(32'h103 >> 2) & 63] = 32'h80FF_FF00;
        run_op(1, 0, 3'b000, 32'h0000_0103, 32'd0, 5'd6, 1, 0, 0);
        chk("lb_lit_data", Wb_RegWData, 32'hFFFF_FF80);
        chk("lb_lit_stalls", last_stalls, 32'd3);
        run_op(1, 0, 3'b100, 32'h0000_0103, 32'd0, 5'd6, 1, 0, 0);
        chk("lbu_lit_data", Wb_RegWData, 32'h0000_0080);

        run_op(0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd0, 0, 0, 0);
        chk("sh_lit_strb", {28'd0, last_wstrb}, 32'h0000_000C);
        chk("sh_lit_wdata", last_wdata, 32'hABCD_ABCD);
        chk("sh_lit_addr", last_addr, 32'h0000_0200);
        chk1("sh_lit_we", last_we, 1'b1);

        run_op(1, 0, 3'b010, 32'h0000_0040, 32'd0, 5'd9, 1, 4, 1);
        run_op(1, 0, 3'b010, 32'h0000_0101, 32'd0, 5'd9, 1, 0, 0);
        run_op(1, 0, 3'b010, 32'h0000_0044, 32'd0, 5'd10, 1, 0, 100);
        chk("to_lit_stalls", last_stalls, 32'd9);

        // Reset in the middle of a load, with a response arriving during and after reset.
        @(posedge clk); #1;
        ExMem_MemRead = 1'b1; ExMem_MemToReg = 1'b1; ExMem_RegWrite = 1'b1;
        ExMem_RegRd = 5'd7; ExMem_Funct3 = 3'b010; ExMem_AluResult = 32'h0000_0048;
        @(negedge clk);
        @(negedge clk); dmem_req_ready = 1'b1;
        @(negedge clk); dmem_req_ready = 1'b0; rst = 1'b1;
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst = 1'b0;
        set_nop();
        @(negedge clk);
        chk1("rrst_stall", mem_stall, 1'b0);
        chk1("rrst_valid", dmem_req_valid, 1'b0);
        chk1("rrst_wb_we", MemWb_RegWrite, 1'b0);
        chk("rrst_wb_data", Wb_RegWData, 32'd0);
        chk1("rrst_err", mem_err, 1'b0);
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b0;
        @(negedge clk);
        chk1("rrst_ignored_we", MemWb_RegWrite, 1'b0);
        chk1("rrst_ignored_stall", mem_stall, 1'b0);
        mem[18] = 32'h1357_9BDF;
        run_op(1, 0, 3'b010, 32'h0000_0048, 32'd0, 5'd7, 1, 1, 2);
        chk("rrst_next_lw", Wb_RegWData, 32'h1357_9BDF);

        for (int i = 0; i < 200; i++) begin
            int          kind, r, s;
            logic [2:0]  f3;
            logic [31:0] a, d;
            logic [4:0]  rd;
            kind = $urandom_range(0, 3);
            a    = $urandom();
            d    = $urandom();
            rd   = 5'($urandom_range(1, 31));
            r    = $urandom_range(0, 3);
            s    = ($urandom_range(0, 15) == 0) ? 20 : $urandom_range(0, 3);
            case (kind)
                0: begin f3 = 3'($urandom_range(0, 7)); run_op(0, 0, f3, a, d, rd, 1, r, s); end
                1: begin f3 = 3'($urandom_range(0, 7)); run_op(1, 0, f3, a, d, rd, 1, r, s); end
                2: begin f3 = 3'($urandom_range(0, 2)); run_op(0, 1, f3, a, d, rd, 0, r, s); end
                default: begin f3 = 3'($urandom_range(0, 2)); run_op(1, 1, f3, a, d, rd, 0, r, s); end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
